// File: rtl/fpro_mstr_pkg.sv
// Shared types and address-field constants for the FPro MMIO bus master.
package fpro_mstr_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} mstr_state_t;

  localparam int SLOT_LSB = 5;
  localparam int SLOT_W   = 6;

  function automatic logic [SLOT_W-1:0] slot_of(input logic [20:0] addr);
    return addr[SLOT_LSB +: SLOT_W];
  endfunction

endpackage

// File: rtl/fpro_mmio_master_if.sv
// Request/response channels plus the MMIO strobe bus of fpro_mmio_master.
// master = the bus initiator (DUT) view, slave = requester plus MMIO subsystem view.
interface fpro_mmio_master_if #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [LEN_W-1:0]  req_len;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_last;

  logic              busy;

  logic              mmio_cs;
  logic              mmio_wr;
  logic              mmio_rd;
  logic [ADDR_W-1:0] mmio_addr;
  logic [DATA_W-1:0] mmio_wr_data;
  logic [DATA_W-1:0] mmio_rd_data;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, req_len, rsp_ready, mmio_rd_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_last, busy,
           mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, req_len, rsp_ready, mmio_rd_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last, busy,
           mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
  );

endinterface

// File: rtl/fpro_mmio_master.sv
// FPro MMIO bus initiator: request/response handshakes in, one-cycle cs/wr/rd strobes out.
// FPRO_MSTR_BURST_EN enables auto-incrementing bursts of req_len+1 beats.
module fpro_mmio_master
  import fpro_mstr_pkg::*;
#(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  fpro_mmio_master_if.master  bus
);

  mstr_state_t       state_q, state_d;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              last;
  logic              req_hs;

  assign req_hs = bus.req_valid && bus.req_ready;

`ifdef FPRO_MSTR_BURST_EN
  logic [LEN_W-1:0] cnt_q;
  logic             advance;

  assign last = (cnt_q == '0);
  // Move to the next beat: back-to-back on writes, after each response on reads.
  assign advance = !last && ((state_q == ACCESS && wr_q) ||
                             (state_q == RESP && bus.rsp_ready));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (req_hs) begin
      cnt_q <= bus.req_len;
    end else if (advance) begin
      cnt_q <= cnt_q - LEN_W'(1);
    end
  end
`else
  assign last = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_hs) state_d = ACCESS;
      ACCESS:  if (!wr_q || last) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = last ? IDLE : ACCESS;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready    = 1'b0;
    bus.rsp_valid    = 1'b0;
    bus.rsp_last     = 1'b0;
    bus.busy         = (state_q != IDLE);
    bus.mmio_cs      = 1'b0;
    bus.mmio_wr      = 1'b0;
    bus.mmio_rd      = 1'b0;
    bus.mmio_addr    = '0;
    bus.mmio_wr_data = '0;
    case (state_q)
      IDLE: bus.req_ready = !reset;
      ACCESS: begin
        bus.mmio_cs      = 1'b1;
        bus.mmio_wr      = wr_q;
        bus.mmio_rd      = !wr_q;
        bus.mmio_addr    = addr_q;
        bus.mmio_wr_data = wr_q ? wdata_q : '0;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_last  = last;
      end
      default: ;
    endcase
  end

  assign bus.rsp_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
    end else if (req_hs) begin
      addr_q <= bus.req_addr;
`ifdef FPRO_MSTR_BURST_EN
    end else if (advance) begin
      addr_q <= addr_q + ADDR_W'(1);
`endif
    end
  end

  // rdata_q only changes in ACCESS, so it is stable for the whole RESP stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (req_hs) begin
        wr_q    <= bus.req_wr;
        wdata_q <= bus.req_wdata;
      end
      if (state_q == ACCESS) begin
        if (!wr_q) begin
          rdata_q <= bus.mmio_rd_data;
        end else if (last) begin
          rdata_q <= '0;
        end
      end
    end
  end

endmodule
